// File: rtl/uart_rx_deframer_pkg.sv
// Shared types and frame-format constants for the UART receive path.
// The future transmitter imports the same package.
package uart_rx_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_DIV = 868;  // 100 MHz / 115200 baud
  localparam int DATA_BITS   = 8;
  localparam int STOP_BITS   = 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with a falling-edge detector. All flops reset to 1,
// so an idle-high line never produces a spurious edge when reset releases.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign fall = prev & ~q;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 receiver: oversamples rxd, recovers bytes and hands them to the FIFO
// write side through a single-entry valid/ready slot.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int DIV      = DEFAULT_DIV,
  parameter int CNT_BITS = 16
) (
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic       rxd,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_BITS-1:0] HALF_M1  = CNT_BITS'(DIV / 2 - 1);
  localparam logic [CNT_BITS-1:0] FULL_M1  = CNT_BITS'(DIV - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t             state, state_nxt;
  logic [CNT_BITS-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DATA_BITS-1:0]  shreg, shreg_nxt;
  logic                  rx_s, fall;
  logic                  stop_tick, slot_free, load, ferr_nxt, ovr_nxt;

  uart_rx_sync u_sync (
    .clk  (s_clk),
    .rst  (s_rst),
    .d    (rxd),
    .q    (rx_s),
    .fall (fall)
  );

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_BITS'(1);
    idx_nxt   = idx;
    shreg_nxt = shreg;
    case (state)
      IDLE: begin
        // Only a real 1->0 transition starts a frame; a held-low line does not.
        cnt_nxt = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          idx_nxt   = idx + IDX_W'(1);
          if (idx == LAST_IDX) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stop_tick = (state == STOP) && (cnt == FULL_M1);
    // A beat accepted this cycle frees the slot for a same-cycle load.
    slot_free = ~m_valid | m_ready;
    load      = stop_tick & rx_s & slot_free;
    ovr_nxt   = stop_tick & rx_s & ~slot_free;
    ferr_nxt  = stop_tick & ~rx_s;
    busy      = (state != IDLE);
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      m_valid   <= load | (m_valid & ~m_ready);
      if (load) m_data <= shreg;
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
    end
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Asynchronous serial receiver sitting directly upstream of the UART receive FIFO.
- Oversamples the raw RXD pin, recovers 8N1 frames and presents each byte on a valid/ready handshake that drives the FIFO write side (s_valid/s_ready/s_data).
- Flags framing errors and overruns, i.e. bytes lost because the FIFO was full.
- Runs entirely in the FIFO write-clock domain.

Parameters:
- DIV, 868, clock cycles per bit period (100 MHz / 115200). Legal range 8..65535; DIV/2 uses integer division.
- CNT_BITS, 16, width of the bit-period counter. Must satisfy 2^CNT_BITS > DIV.

Ports:
- s_clk  input  1  receive clock, same clock as the FIFO write side.
- s_rst  input  1  reset, asynchronous, active-high.
- rxd  input  1  raw serial line, idle high, asynchronous to s_clk.
- m_valid  output  1  byte available; connects to FIFO s_valid.
- m_ready  input  1  downstream accepts; connects to FIFO s_ready.
- m_data  output  8  received byte; connects to FIFO s_data.
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- overrun  output  1  one-cycle pulse: new byte completed while m_valid=1 and m_ready=0, new byte discarded.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is async assert and clears: state=IDLE, counter=0, bit index=0, shift reg=0, m_valid=0, m_data=0, frame_err=0, overrun=0, busy=0. Both synchronizer flops and the edge-history flop reset to 1 (line idle).
- Input path: rxd passes through a 2-flop synchronizer to give rx_s. A falling edge is rx_s==0 while the previous rx_s==1.
- IDLE:
  - A falling edge moves to START with cnt=0.
  - A line held low (break, or after a framing error) never starts a frame. A 1->0 transition is required.
- START:
  - cnt increments each cycle.
  - At cnt==DIV/2-1, sample rx_s.
  - If rx_s==0: go to DATA, cnt=0, bit index=0.
  - If rx_s==1: treat as a glitch and return to IDLE. No pulse is raised.
- DATA:
  - At cnt==DIV-1, sample rx_s into the shift register, LSB first (shift right, new bit enters bit 7). Then set cnt=0 and bit index +1.
  - After the 8th sample (bit index 7), go to STOP.
- STOP:
  - At cnt==DIV-1, sample rx_s and go to IDLE in the same cycle.
  - If rx_s==1 and the output slot is free, load m_data with the shift register and set m_valid=1 on the next edge.
  - If rx_s==1 and the slot is full, pulse overrun for 1 cycle. m_data and m_valid are unchanged.
  - If rx_s==0, pulse frame_err for 1 cycle. The byte is dropped and m_valid is unchanged.
- Output slot (single entry):
  - m_valid clears on any cycle where m_valid & m_ready.
  - The slot counts as free for a STOP load in that same cycle (accept and load coincide). m_valid stays 1 and m_data takes the new byte.
  - m_data is stable while m_valid=1 and m_ready=0.
- Latency: m_valid rises 1 cycle after the mid-stop sample, about 9.5 bit periods plus 3 cycles after the start edge on rxd.
- Counter width: cnt compares at CNT_BITS width. There is no wrap-around in legal operation.
- Reset mid-frame: the partial byte is lost and the FSM resumes in IDLE. A line still low at reset release is not taken as a start.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - the default DIV constant
  - the frame-format constants DATA_BITS=8 and STOP_BITS=1
- One natural sub-module: uart_rx_sync (2-flop synchronizer plus edge detector, reset-to-1). It is reusable by the future transmitter's CTS input.

Test Plan:
- DIV=16, send 0xA5 as 8N1, m_ready=1 -> exactly one m_valid beat with m_data=0xA5; frame_err=0, overrun=0; m_valid rises 155±3 cycles after the start edge.
- Send 0x3C with the stop bit forced low -> frame_err pulses 1 cycle; m_valid stays 0. A following valid 0x81 after the line returns high -> received as 0x81.
- Hold m_ready=0, send 0x11 then 0x22 -> m_valid=1 with m_data=0x11 throughout; overrun pulses once at the second stop sample. Raise m_ready -> one beat of 0x11, then m_valid=0.
- Drive m_ready high in exactly the cycle the second byte's stop is sampled -> the 0x11 beat completes, m_data=0x22 next cycle, m_valid stays 1, no overrun.
- 5-cycle low glitch on an idle rxd -> returns to IDLE at the START mid-sample; no m_valid, no error pulses; busy high for 8 cycles only.
- Assert s_rst during DATA of byte 0x55, release with the line high, then send 0x0F -> only 0x0F delivered; all outputs 0 during reset.
